pmem_arbiter: RTL

- Shares the core's single physical-memory port between the instruction-fetch requester (read-only) and the memory-access requester (read/write).
- Sits between InstFetch/MemoryAccess and the pmem DPI wrapper.
- Arbitration is data-priority with a starvation guard. One transaction is outstanding at a time.
- Downstream memory may take any number of cycles to acknowledge.

---
 rtl/pmem_arbiter_pkg.sv | 23 ++
 rtl/pmem_arbiter_if.sv | 42 ++++
 rtl/pmem_arbiter_select.sv | 40 ++++
 rtl/pmem_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and widths for the physical-memory port arbiter.
package pmem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MASK_WIDTH = 4;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Fetch, data and downstream memory signals of the arbiter, bundled.
interface pmem_arbiter_if;
  import pmem_arbiter_pkg::*;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MASK_WIDTH-1:0] d_wmask;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  // Requesters and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/pmem_arbiter_select.sv
// Data-priority grant selection with a starvation guard for the fetch side.
module pmem_arbiter_select
  import pmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sel_en,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] d_streak_q;
  logic                starved;

  assign starved = (d_streak_q == STREAK_MAX);
  assign i_gnt   = sel_en && i_req && (!d_req || starved);
  assign d_gnt   = sel_en && d_req && !i_gnt;

  // Count data grants that overtook a waiting fetch; any other grant clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      d_streak_q <= '0;
    end else if (i_gnt) begin
      d_streak_q <= '0;
    end else if (d_gnt) begin
      if (!i_req) begin
        d_streak_q <= '0;
      end else if (!starved) begin
        d_streak_q <= d_streak_q + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between instruction fetch and data access,
// one outstanding transaction at a time.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input logic           clock,
  input logic           reset,
  pmem_arbiter_if.slave bus
);

  arb_state_e            state_q, state_d;
  mem_req_t              req_q;
  logic                  mem_req_q;
  logic                  i_rvalid_q, d_rvalid_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic                  sel_en, i_gnt, d_gnt, ack;

  assign sel_en = (state_q == IDLE) || (state_q == RESP);
  assign ack    = bus.mem_ack && mem_req_q && ((state_q == BUSY_I) || (state_q == BUSY_D));

  pmem_arbiter_select #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_select (
    .clock  (clock),
    .reset  (reset),
    .sel_en (sel_en),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .i_gnt  (i_gnt),
    .d_gnt  (d_gnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (i_gnt)      state_d = BUSY_I;
        else if (d_gnt) state_d = BUSY_D;
        else            state_d = IDLE;
      end
      BUSY_I, BUSY_D: begin
        if (ack) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request register, downstream handshake and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q      <= '0;
      mem_req_q  <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      if (i_gnt) begin
        req_q     <= '{we: 1'b0, addr: bus.i_addr, wdata: '0, wmask: '0};
        mem_req_q <= 1'b1;
      end else if (d_gnt) begin
        req_q     <= '{we:    bus.d_we,
                       addr:  bus.d_addr,
                       wdata: bus.d_wdata,
                       wmask: bus.d_we ? bus.d_wmask : '0};
        mem_req_q <= 1'b1;
      end else if (ack) begin
        mem_req_q <= 1'b0;
      end
      if (ack) begin
        if (state_q == BUSY_I) begin
          i_rvalid_q <= 1'b1;
          i_rdata_q  <= bus.mem_rdata;
        end else begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= req_q.we ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = req_q.we;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_wmask = req_q.wmask;

endmodule
